// File: rtl/perf_monitor_pkg.sv
// perf_monitor_pkg: shared types and default constants for the performance monitor.
//   chan_state_t  - per-channel measurement state
//   DEF_*         - default parameter values used by perf_monitor
//   RES_W         - width of each per-channel residual (cycles-into-unit) field
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } chan_state_t;

  localparam int unsigned DEF_WATCH_W       = 16;
  localparam int unsigned DEF_NCH           = 4;
  localparam int unsigned DEF_PRESCALE      = 1000;
  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned DEF_TIMEOUT_UNITS = 150;
  localparam int unsigned RES_W             = 16;

endpackage

// File: rtl/perf_channel.sv
// perf_channel: one measurement channel of perf_monitor.
//   clock, resetb       - clock, asynchronous active-low reset
//   start_ev, stop_ev   - one-cycle pattern-entry events from the top
//   enable              - arm; low forces RUN back to IDLE (counters kept)
//   clear               - synchronous return to IDLE, counters and flags cleared
//   units, residual     - completed units and cycles into the current unit
//   busy, done, timeout - in RUN, one-cycle DONE-entry pulse, sticky timeout flag
module perf_channel
  import perf_monitor_pkg::*;
#(
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned TIMEOUT_UNITS = DEF_TIMEOUT_UNITS
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start_ev,
  input  logic             stop_ev,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] units,
  output logic [RES_W-1:0] residual,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W:0] UNIT_LIMIT = (CNT_W + 1)'(TIMEOUT_UNITS);

  chan_state_t      state;
  logic             res_wrap;
  logic [RES_W-1:0] res_inc;
  logic [CNT_W-1:0] units_inc;
  logic             hit_limit;

  // Next counter values for one counted cycle; units saturates at all-ones.
  always_comb begin
    res_wrap  = (residual == RES_W'(PRESCALE - 1));
    res_inc   = res_wrap ? '0 : residual + RES_W'(1);
    units_inc = units;
    if (res_wrap && (units != '1)) begin
      units_inc = units + CNT_W'(1);
    end
    hit_limit = res_wrap && ({1'b0, units_inc} == UNIT_LIMIT);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      units    <= '0;
      residual <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state    <= ST_IDLE;
        units    <= '0;
        residual <= '0;
        busy     <= 1'b0;
        timeout  <= 1'b0;
      end else if (!enable) begin
        if (state == ST_RUN) begin
          state <= ST_IDLE;
        end
        busy <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (stop_ev) begin
              // The stop edge still counts, so the frozen value equals the
              // number of cycles between the start and stop entries.
              state    <= ST_DONE;
              units    <= units_inc;
              residual <= res_inc;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (start_ev) begin
              units    <= '0;
              residual <= '0;
            end else begin
              units    <= units_inc;
              residual <= res_inc;
              if (hit_limit) begin
                state   <= ST_TIMEOUT;
                busy    <= 1'b0;
                timeout <= 1'b1;
              end
            end
          end
          default: begin
            if (start_ev) begin
              state    <= ST_RUN;
              units    <= '0;
              residual <= '0;
              busy     <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: multi-channel interval timer triggered by patterns on a status bus.
//   clock, resetb       - clock, asynchronous active-low reset
//   watch               - observed status bus (double registered before use)
//   start_pat, stop_pat - per-channel patterns, channel n in slice n
//   enable, clear       - per-channel arm and synchronous clear
//   units, residual     - per-channel completed units / cycles into current unit
//   busy, done, timeout - per-channel RUN flag, DONE-entry pulse, sticky timeout
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int unsigned WATCH_W       = DEF_WATCH_W,
  parameter int unsigned NCH           = DEF_NCH,
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned TIMEOUT_UNITS = DEF_TIMEOUT_UNITS
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic [WATCH_W-1:0]     watch,
  input  logic [NCH*WATCH_W-1:0] start_pat,
  input  logic [NCH*WATCH_W-1:0] stop_pat,
  input  logic [NCH-1:0]         enable,
  input  logic [NCH-1:0]         clear,
  output logic [NCH*CNT_W-1:0]   units,
  output logic [NCH*RES_W-1:0]   residual,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         timeout
);

  logic [WATCH_W-1:0] watch_q;
  logic [WATCH_W-1:0] watch_qq;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      watch_q  <= '0;
      watch_qq <= '0;
    end else begin
      watch_q  <= watch;
      watch_qq <= watch_q;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [WATCH_W-1:0] spat;
    logic [WATCH_W-1:0] epat;
    logic               start_ev;
    logic               stop_ev;

    assign spat = start_pat[n*WATCH_W +: WATCH_W];
    assign epat = stop_pat[n*WATCH_W +: WATCH_W];

    // Events fire on entry into a pattern, not while the bus holds it.
    assign start_ev = (watch_q == spat) && (watch_qq != spat);
    assign stop_ev  = (watch_q == epat) && (watch_qq != epat);

    perf_channel #(
      .PRESCALE      (PRESCALE),
      .CNT_W         (CNT_W),
      .TIMEOUT_UNITS (TIMEOUT_UNITS)
    ) u_chan (
      .clock    (clock),
      .resetb   (resetb),
      .start_ev (start_ev),
      .stop_ev  (stop_ev),
      .enable   (enable[n]),
      .clear    (clear[n]),
      .units    (units[n*CNT_W +: CNT_W]),
      .residual (residual[n*RES_W +: RES_W]),
      .busy     (busy[n]),
      .done     (done[n]),
      .timeout  (timeout[n])
    );
  end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized scoreboard bench for perf_monitor.
// The model tracks each channel as "running since cycle T"; measured value is the
// elapsed cycle count between pattern entries, split into units/residual.
module tb_perf_monitor;

  localparam int WW = 16;
  localparam int NCH = 4;
  localparam int PS = 20;
  localparam int CW = 8;
  localparam int TU = 15;
  localparam int TP = PS * TU;
  localparam int RW = 16;

  logic              clock = 1'b0;
  logic              resetb = 1'b0;
  logic [WW-1:0]     watch;
  logic [NCH*WW-1:0] start_pat;
  logic [NCH*WW-1:0] stop_pat;
  logic [NCH-1:0]    enable;
  logic [NCH-1:0]    clear;
  logic [NCH*CW-1:0] units;
  logic [NCH*RW-1:0] residual;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    timeout;

  perf_monitor #(
    .WATCH_W       (WW),
    .NCH           (NCH),
    .PRESCALE      (PS),
    .CNT_W         (CW),
    .TIMEOUT_UNITS (TU)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .watch     (watch),
    .start_pat (start_pat),
    .stop_pat  (stop_pat),
    .enable    (enable),
    .clear     (clear),
    .units     (units),
    .residual  (residual),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 1 = done, 2 = timeout, 0 = busy dropped otherwise (clear / disable)
  typedef struct {
    int kind;
    int units;
    int res;
  } exp_t;

  exp_t sb[NCH][$];
  int checks = 0;
  int errors = 0;

  logic [WW-1:0] spat[NCH];
  logic [WW-1:0] epat[NCH];
  logic [WW-1:0] wprev;
  bit running[NCH];
  bit timed_out[NCH];
  int t_start[NCH];
  int fr_units[NCH];
  int fr_res[NCH];

  function automatic void chk(string name, int n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0d expected=%0d", name, n, act, exp);
    end
  endfunction

  function automatic void push(int n, int kind, int e);
    exp_t x;
    x.kind = kind;
    x.units = e / PS;
    x.res = e % PS;
    sb[n].push_back(x);
    fr_units[n] = x.units;
    fr_res[n] = x.res;
  endfunction

  // Called at every negedge: a run older than the limit has timed out.
  function automatic void tick();
    for (int n = 0; n < NCH; n++) begin
      if (running[n] && (cyc - t_start[n] > TP)) begin
        push(n, 2, TP);
        running[n] = 0;
        timed_out[n] = 1;
      end
    end
  endfunction

  task automatic step(int k);
    repeat (k) begin
      @(negedge clock);
      tick();
    end
  endtask

  function automatic void change(logic [WW-1:0] v);
    for (int n = 0; n < NCH; n++) begin
      bit se;
      bit pe;
      se = (v == spat[n]) && (wprev != spat[n]);
      pe = (v == epat[n]) && (wprev != epat[n]);
      if (running[n]) begin
        if (pe) begin
          push(n, 1, cyc - t_start[n]);
          running[n] = 0;
        end else if (se) begin
          t_start[n] = cyc;
        end
      end else if (se && enable[n]) begin
        running[n] = 1;
        t_start[n] = cyc;
      end
    end
    wprev = v;
    watch = v;
  endfunction

  task automatic do_clear(int n);
    if (running[n]) push(n, 0, 0);
    running[n] = 0;
    timed_out[n] = 0;
    fr_units[n] = 0;
    fr_res[n] = 0;
    clear[n] = 1'b1;
    step(1);
    clear[n] = 1'b0;
  endtask

  task automatic do_abort(int n);
    enable[n] = 1'b0;
    if (running[n]) begin
      push(n, 0, cyc - t_start[n] - 2);
      running[n] = 0;
    end
    step(3);
    enable[n] = 1'b1;
  endtask

  function automatic void check_state();
    for (int n = 0; n < NCH; n++) begin
      int eu;
      int er;
      if (running[n]) begin
        eu = (cyc - t_start[n] - 2) / PS;
        er = (cyc - t_start[n] - 2) % PS;
      end else begin
        eu = fr_units[n];
        er = fr_res[n];
      end
      chk("state_busy", n, int'(busy[n]), int'(running[n]));
      chk("state_timeout", n, int'(timeout[n]), int'(timed_out[n]));
      chk("state_units", n, int'(units[n*CW +: CW]), eu);
      chk("state_residual", n, int'(residual[n*RW +: RW]), er);
    end
  endfunction

  // Monitor: pops an expectation whenever a channel leaves RUN.
  logic [NCH-1:0] pb;
  logic [NCH-1:0] pd;
  logic [NCH-1:0] pt;

  always @(negedge clock) begin
    if (!resetb) begin
      pb = '0;
      pd = '0;
      pt = '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        exp_t x;
        int ak;
        if (pd[n]) chk("done_width", n, int'(done[n]), 0);
        if (done[n] || (timeout[n] && !pt[n]) || (pb[n] && !busy[n])) begin
          ak = done[n] ? 1 : (timeout[n] ? 2 : 0);
          if (sb[n].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected ch%0d actual_kind=%0d expected=none", n, ak);
          end else begin
            x = sb[n].pop_front();
            chk("ev_kind", n, ak, x.kind);
            chk("ev_units", n, int'(units[n*CW +: CW]), x.units);
            chk("ev_residual", n, int'(residual[n*RW +: RW]), x.res);
          end
        end
      end
      pb = busy;
      pd = done;
      pt = timeout;
    end
  end

  initial begin
    int dl[3];
    int d;
    int r;
    int s;
    spat = '{16'hA000, 16'h1111, 16'h3333, 16'h5555};
    epat = '{16'hAB00, 16'h2222, 16'h4444, 16'h5555};
    for (int n = 0; n < NCH; n++) begin
      start_pat[n*WW +: WW] = spat[n];
      stop_pat[n*WW +: WW] = epat[n];
      running[n] = 0;
      timed_out[n] = 0;
      fr_units[n] = 0;
      fr_res[n] = 0;
      t_start[n] = 0;
    end
    watch = '0;
    wprev = '0;
    enable = '1;
    clear = '0;
    resetb = 1'b0;

    step(3);
    chk("reset_units", 0, int'(units != '0), 0);
    chk("reset_residual", 0, int'(residual != '0), 0);
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_done", 0, int'(done), 0);
    chk("reset_timeout", 0, int'(timeout), 0);
    resetb = 1'b1;
    step(2);

    // Single-channel windows, including one ending exactly at the limit.
    dl = '{$urandom_range(1, TP - 1), $urandom_range(1, TP - 1), TP};
    foreach (dl[i]) begin
      change(16'hA000);
      step(dl[i]);
      change(16'hAB00);
      step(4);
      change(16'h0000);
      step(3);
    end

    // Timeout, stop ignored afterwards, frozen until clear.
    change(16'hA000);
    step(TP + 10);
    change(16'hAB00);
    step(10);
    chk("to_units", 0, int'(units[CW-1:0]), TU);
    chk("to_flag", 0, int'(timeout[0]), 1);
    step(20);
    chk("to_frozen_units", 0, int'(units[CW-1:0]), TU);
    chk("to_frozen_res", 0, int'(residual[RW-1:0]), 0);
    do_clear(0);
    step(2);
    chk("clr_timeout", 0, int'(timeout[0]), 0);
    chk("clr_units", 0, int'(units[CW-1:0]), 0);
    change(16'h0000);
    step(2);

    // Equal start/stop pattern on channel 3.
    repeat (3) begin
      d = $urandom_range(10, TP - 1);
      change(16'h5555);
      step(3);
      change(16'h0000);
      step(d - 3);
      change(16'h5555);
      step(4);
      change(16'h0000);
      step(3);
    end

    // Restart on channel 1.
    repeat (2) begin
      r = $urandom_range(5, 200);
      s = $urandom_range(5, TP - 1);
      change(16'h1111);
      step(2);
      change(16'h0000);
      step(r - 2);
      change(16'h1111);
      step(s);
      change(16'h2222);
      step(4);
      change(16'h0000);
      step(3);
    end

    // Overlapping windows on all channels, channel 2 cleared mid-run.
    repeat (3) begin
      change(16'hA000);
      step($urandom_range(5, 30));
      change(16'h1111);
      step($urandom_range(5, 30));
      change(16'h3333);
      step($urandom_range(5, 30));
      change(16'h5555);
      step($urandom_range(5, 30));
      do_clear(2);
      step($urandom_range(5, 30));
      change(16'h4444);
      step($urandom_range(5, 30));
      change(16'hAB00);
      step($urandom_range(5, 30));
      change(16'h2222);
      step($urandom_range(5, 30));
      change(16'h5555);
      step(4);
      change(16'h0000);
      step(3);
    end
    check_state();

    // Enable dropped mid-run: counters kept, no done pulse.
    change(16'h1111);
    step($urandom_range(20, 200));
    do_abort(1);
    change(16'h0000);
    step(3);
    check_state();

    // Asynchronous reset mid-run, then a bus already at a start pattern.
    change(16'hA000);
    step(50);
    #3;
    resetb = 1'b0;
    #1;
    chk("areset_units", 0, int'(units != '0), 0);
    chk("areset_residual", 0, int'(residual != '0), 0);
    chk("areset_busy", 0, int'(busy), 0);
    chk("areset_timeout", 0, int'(timeout), 0);
    for (int n = 0; n < NCH; n++) begin
      running[n] = 0;
      timed_out[n] = 0;
      fr_units[n] = 0;
      fr_res[n] = 0;
    end
    wprev = '0;
    step(2);
    resetb = 1'b1;
    change(16'hA000);
    d = $urandom_range(10, TP - 1);
    step(d);
    change(16'hAB00);
    step(5);
    check_state();

    for (int n = 0; n < NCH; n++) chk("sb_drain", n, sb[n].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
